// File: rtl/uart_rx_ctrl_if.sv
// CPU-side bus of the UART receive controller.
//  master : the CPU (drives cfg_we/cfg_wdata, rd_ready, ovf_clr)
//  slave  : the controller (drives cfg_busy, rd_valid, rd_data, count, fifo_ovf, irq)
//  cfg_wdata layout is {even, pen, eight, k[18:0]}; rd_data is {ovf, ferr, perr, data[7:0]}.
interface uart_rx_ctrl_if #(
  parameter int AW = 3
);
  logic          cfg_we;
  logic [21:0]   cfg_wdata;
  logic          cfg_busy;
  logic          rd_valid;
  logic          rd_ready;
  logic [10:0]   rd_data;
  logic [AW:0]   count;
  logic          fifo_ovf;
  logic          ovf_clr;
  logic          irq;

  modport master (
    output cfg_we, cfg_wdata, rd_ready, ovf_clr,
    input  cfg_busy, rd_valid, rd_data, count, fifo_ovf, irq
  );

  modport slave (
    input  cfg_we, cfg_wdata, rd_ready, ovf_clr,
    output cfg_busy, rd_valid, rd_data, count, fifo_ovf, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// Drains each character the receive engine flags as ready into an RX FIFO,
// clears the engine with a one-cycle eng_clr pulse, and presents the FIFO to
// the CPU as a valid/ready read port with a level interrupt. It also owns the
// engine's frame configuration and only changes it while the engine is idle.
// Ports:
//  clk, rst                 clock, asynchronous active-low reset
//  bus (slave)              CPU side: config write, read port, count, fifo_ovf, irq
//  k, eight, pen, even      frame configuration driven to the engine
//  eng_idle, eng_rxrdy      engine idle / character-ready status
//  eng_data, eng_perr,
//  eng_ferr, eng_ovf        received character and its error flags
//  eng_clr                  one-cycle clear back to the engine
module uart_rx_ctrl #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter int          THRESH    = 4,
  parameter logic [18:0] K_DEFAULT = 19'd5208
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_ctrl_if.slave bus,
  output logic [18:0] k,
  output logic        eight,
  output logic        pen,
  output logic        even,
  input  logic        eng_idle,
  input  logic        eng_rxrdy,
  input  logic [7:0]  eng_data,
  input  logic        eng_perr,
  input  logic        eng_ferr,
  input  logic        eng_ovf,
  output logic        eng_clr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_CLR
  } state_e;

  typedef struct packed {
    logic       ovf;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  typedef struct packed {
    logic        even;
    logic        pen;
    logic        eight;
    logic [18:0] k;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{even: 1'b0, pen: 1'b0, eight: 1'b1, k: K_DEFAULT};

  state_e          state_q, state_d;
  logic            eng_clr_q, eng_clr_d;
  rx_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            fifo_ovf_q, fifo_ovf_d;
  logic            irq_q, irq_d;
  cfg_t            cfg_q, cfg_d;
  cfg_t            pend_q, pend_d;
  logic            busy_q, busy_d;

  logic            capture;
  logic            full;
  logic            rd_valid;
  logic            push;
  logic            pop;
  logic            apply;
  rx_entry_t       head;
  rx_entry_t       cap_entry;

  assign capture   = (state_q == ST_CAPTURE);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid & bus.rd_ready;
  // A full FIFO can still accept the capture when the CPU frees a slot on the same edge.
  assign push      = capture & (~full | pop);
  assign head      = mem_q[rd_ptr_q];
  assign cap_entry = '{ovf: eng_ovf, ferr: eng_ferr, perr: eng_perr, data: eng_data};
  // Config may only move while the engine is searching for a start bit and no
  // character is waiting to be drained, so a frame never sees a mid-flight change.
  assign apply     = busy_q & eng_idle & (state_q == ST_IDLE) & ~eng_rxrdy;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    eng_clr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (eng_rxrdy) begin
          state_d   = ST_CAPTURE;
          eng_clr_d = 1'b1;
        end
      end
      ST_CAPTURE:  state_d = ST_WAIT_CLR;
      // Wait for the engine to drop its sticky flag so one character is taken once.
      ST_WAIT_CLR: if (!eng_rxrdy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Losing a character outranks a simultaneous clear.
    if (capture && !push)  fifo_ovf_d = 1'b1;
    else if (bus.ovf_clr)  fifo_ovf_d = 1'b0;
    else                   fifo_ovf_d = fifo_ovf_q;

    irq_d = (count_q >= (AW+1)'(THRESH)) | fifo_ovf_q |
            (rd_valid & (head.perr | head.ferr | head.ovf));

    cfg_d  = apply ? pend_q : cfg_q;
    pend_d = bus.cfg_we ? cfg_t'(bus.cfg_wdata) : pend_q;
    // A write landing on the apply edge stays pending for the next idle window.
    busy_d = bus.cfg_we | (busy_q & ~apply);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      eng_clr_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_ovf_q <= 1'b0;
      irq_q      <= 1'b0;
      cfg_q      <= CFG_RESET;
      pend_q     <= CFG_RESET;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      eng_clr_q  <= eng_clr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_ovf_q <= fifo_ovf_d;
      irq_q      <= irq_d;
      cfg_q      <= cfg_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cap_entry;
  end

  assign eng_clr      = eng_clr_q;
  assign k            = cfg_q.k;
  assign eight        = cfg_q.eight;
  assign pen          = cfg_q.pen;
  assign even         = cfg_q.even;

  assign bus.cfg_busy = busy_q;
  assign bus.rd_valid = rd_valid;
  // Gate the head so an empty FIFO reads as zero rather than stale storage.
  assign bus.rd_data  = rd_valid ? 11'(head) : 11'd0;
  assign bus.count    = count_q;
  assign bus.fifo_ovf = fifo_ovf_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios for reset, single
// capture, fill/overflow, full-with-pop, error entries and deferred config,
// then randomized traffic, all compared against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int          DEPTH  = 8;
  localparam int          AW     = 3;
  localparam int          THRESH = 4;
  localparam logic [18:0] K_DEF  = 19'd5208;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] k;
  logic        eight, pen, even;
  logic        eng_idle  = 1'b1;
  logic        eng_rxrdy = 1'b0;
  logic [7:0]  eng_data  = 8'h00;
  logic        eng_perr  = 1'b0;
  logic        eng_ferr  = 1'b0;
  logic        eng_ovf   = 1'b0;
  logic        eng_clr;

  uart_rx_ctrl_if #(.AW(AW)) bus ();

  uart_rx_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .K_DEFAULT(K_DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .k         (k),
    .eight     (eight),
    .pen       (pen),
    .even      (even),
    .eng_idle  (eng_idle),
    .eng_rxrdy (eng_rxrdy),
    .eng_data  (eng_data),
    .eng_perr  (eng_perr),
    .eng_ferr  (eng_ferr),
    .eng_ovf   (eng_ovf),
    .eng_clr   (eng_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries are {ovf, ferr, perr, data}; config words are {even, pen, eight, k}.
  logic [10:0] q_m[$];
  bit          ovf_m    = 1'b0;
  bit          irq_m    = 1'b0;
  bit          busy_m   = 1'b0;
  logic [21:0] cur_m    = {3'b001, K_DEF};
  logic [21:0] pend_m   = '0;
  bit          cap_now  = 1'b0;   // the bench marks the edge on which a capture lands
  logic [10:0] cap_ent  = '0;
  bit          mon_en   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m.delete();
      ovf_m  = 1'b0;
      irq_m  = 1'b0;
      busy_m = 1'b0;
      cur_m  = {3'b001, K_DEF};
    end else begin
      bit do_pop, do_apply, irq_next;
      do_pop   = bus.rd_ready && (q_m.size() > 0);
      irq_next = (q_m.size() >= THRESH) || ovf_m ||
                 ((q_m.size() > 0) && (q_m[0][10:8] != 3'b000));
      // The bench keeps eng_idle low for the whole life of a character, so
      // idle and no ready flag is exactly the window the controller may apply in.
      do_apply = busy_m && eng_idle && !eng_rxrdy;
      if (do_pop) void'(q_m.pop_front());
      if (cap_now && q_m.size() < DEPTH) q_m.push_back(cap_ent);
      else if (cap_now)                  ovf_m = 1'b1;
      else if (bus.ovf_clr)              ovf_m = 1'b0;
      irq_m = irq_next;
      if (do_apply) cur_m = pend_m;
      if (bus.cfg_we) begin
        pend_m = bus.cfg_wdata;
        busy_m = 1'b1;
      end else if (do_apply) begin
        busy_m = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && mon_en) begin
      check("count",    32'(bus.count),    32'(q_m.size()));
      check("rd_valid", 32'(bus.rd_valid), 32'(q_m.size() > 0));
      check("rd_data",  32'(bus.rd_data),  (q_m.size() > 0) ? 32'(q_m[0]) : 32'd0);
      check("fifo_ovf", 32'(bus.fifo_ovf), 32'(ovf_m));
      check("irq",      32'(bus.irq),      32'(irq_m));
      check("cfg_busy", 32'(bus.cfg_busy), 32'(busy_m));
      check("cfg_out",  32'({even, pen, eight, k}), 32'(cur_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the controller idle. Models an engine
  // that raises rxrdy, sees eng_clr, and drops its flag one edge later.
  task automatic send_char(input logic [7:0] d, input logic [2:0] flags,
                           input bit pop_at_cap, input int hold);
    eng_idle     = 1'b0;
    bus.rd_ready = 1'b0;
    eng_data     = d;
    {eng_ovf, eng_ferr, eng_perr} = flags;
    cap_ent      = {flags, d};
    eng_rxrdy    = 1'b1;
    step();                         // controller notices rxrdy
    cap_now      = 1'b1;
    bus.rd_ready = pop_at_cap;
    @(negedge clk);
    check("eng_clr_hi", 32'(eng_clr), 32'd1);
    step();                         // capture edge
    cap_now      = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    check("eng_clr_lo", 32'(eng_clr), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("eng_clr_hold", 32'(eng_clr), 32'd0);
    end
    step();
    eng_rxrdy = 1'b0;
    {eng_ovf, eng_ferr, eng_perr} = 3'b000;
    step();                         // controller returns to idle
    eng_idle  = 1'b1;
  endtask

  task automatic pop_n(input int n);
    bus.rd_ready = 1'b1;
    repeat (n) step();
    bus.rd_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    check("rst_fifo_ovf", 32'(bus.fifo_ovf), 32'd0);
    check("rst_eng_clr",  32'(eng_clr),      32'd0);
    check("rst_irq",      32'(bus.irq),      32'd0);
    check("rst_k",        32'(k),            32'd5208);
    check("rst_eight",    32'(eight),        32'd1);
    check("rst_pen",      32'(pen),          32'd0);
    check("rst_even",     32'(even),         32'd0);
    check("rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = '0;
    bus.rd_ready  = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    step();
    mon_en = 1'b1;

    // Single character, flag held high for a while afterwards
    send_char(8'hA5, 3'b000, 1'b0, 3);
    @(negedge clk);
    check("t2_rd_data", 32'(bus.rd_data), 32'h0A5);
    check("t2_count",   32'(bus.count),   32'd1);
    step();
    pop_n(1);

    // Fill to DEPTH, then one more
    for (int i = 0; i < DEPTH; i++) send_char(8'(8'h10 + i), 3'b000, 1'b0, 0);
    @(negedge clk);
    check("t3_count_full", 32'(bus.count), 32'd8);
    check("t3_irq",        32'(bus.irq),   32'd1);
    step();
    send_char(8'h99, 3'b000, 1'b0, 0);
    @(negedge clk);
    check("t3_ovf",        32'(bus.fifo_ovf), 32'd1);
    check("t3_count_held", 32'(bus.count),    32'd8);
    step();

    // Full FIFO with a pop on the capture edge
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    send_char(8'h5A, 3'b000, 1'b1, 0);
    @(negedge clk);
    check("t4_count", 32'(bus.count),    32'd8);
    check("t4_ovf",   32'(bus.fifo_ovf), 32'd0);
    step();
    pop_n(DEPTH);

    // Error entry
    send_char(8'h3C, 3'b011, 1'b0, 0);
    @(negedge clk);
    check("t5_rd_data", 32'(bus.rd_data), 32'h33C);
    check("t5_irq",     32'(bus.irq),     32'd1);
    step();
    pop_n(1);
    step();
    @(negedge clk);
    check("t5_irq_drop", 32'(bus.irq), 32'd0);
    step();

    // Deferred config
    eng_idle      = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = {1'b1, 1'b1, 1'b0, 19'd2604};
    step();
    bus.cfg_we    = 1'b0;
    @(negedge clk);
    check("t6_busy",   32'(bus.cfg_busy), 32'd1);
    check("t6_k_held", 32'(k),            32'd5208);
    step();
    step();
    eng_idle = 1'b1;
    step();
    @(negedge clk);
    check("t6_k",     32'(k),            32'd2604);
    check("t6_eight", 32'(eight),        32'd0);
    check("t6_pen",   32'(pen),          32'd1);
    check("t6_even",  32'(even),         32'd1);
    check("t6_busy0", 32'(bus.cfg_busy), 32'd0);
    step();

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_char(8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end else begin
        bus.rd_ready  = ($urandom_range(0, 2) == 0);
        bus.ovf_clr   = ($urandom_range(0, 7) == 0);
        bus.cfg_we    = ($urandom_range(0, 5) == 0);
        bus.cfg_wdata = 22'($urandom);
        eng_idle      = 1'($urandom_range(0, 1));
        step();
        bus.rd_ready  = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.cfg_we    = 1'b0;
        eng_idle      = 1'b1;
      end
    end

    // Reset in the middle of a capture with three entries queued and a config pending
    pop_n(DEPTH);
    for (int i = 0; i < 3; i++) send_char(8'(8'hC0 + i), 3'b000, 1'b0, 0);
    eng_idle      = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = {1'b0, 1'b1, 1'b1, 19'd100};
    step();
    bus.cfg_we    = 1'b0;
    eng_data      = 8'h77;
    eng_rxrdy     = 1'b1;
    step();                         // controller is now capturing
    @(negedge clk);
    check("t1_pre_count", 32'(bus.count), 32'd3);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_reset_values();
    eng_rxrdy = 1'b0;
    eng_idle  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("t1_k_kept", 32'(k), 32'd5208);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
